// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM states and
// register-index constants.
package hazard_ctrl_pkg;
  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  localparam int unsigned REG_W = 5;
  localparam logic [REG_W-1:0] X0 = '0;
endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter: counts inc cycles and holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (inc && !(&count))
      count <= count + 1'b1;
  end
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush and
// data-memory wait, with saturating stall/flush event counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_br_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_load,
  output logic             ifid_load,
  output logic             idex_load,
  output logic             exmem_load,
  output logic             memwb_load,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  state_e state_q, state_d;
  logic   lu, mw;

  assign lu = ex_mem_read && (ex_rd != X0) &&
              ((id_use_rs1 && (id_rs1 == ex_rd)) ||
               (id_use_rs2 && (id_rs2 == ex_rd)));
  assign mw = mem_req && !mem_ready;

  // Outputs do not depend on state: MEM_WAIT only ever freezes via mw, and
  // once mem_ready arrives the held EX inputs are decoded exactly as in RUN.
  always_comb begin
    pc_load    = 1'b1;
    ifid_load  = 1'b1;
    idex_load  = 1'b1;
    exmem_load = 1'b1;
    memwb_load = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (mw) begin
      pc_load    = 1'b0;
      ifid_load  = 1'b0;
      idex_load  = 1'b0;
      exmem_load = 1'b0;
      memwb_load = 1'b0;
    end else if (ex_br_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (lu) begin
      pc_load    = 1'b0;
      ifid_load  = 1'b0;
      idex_flush = 1'b1;
    end
  end

  always_comb begin
    state_d = RUN;
    if (mw) state_d = MEM_WAIT;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (!pc_load),
    .count(stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (ifid_flush),
    .count(flush_cnt)
  );
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: vector table plus multi-cycle sequences
// for memory wait, reset during wait and counter saturation.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_mem_read, ex_br_taken, mem_req, mem_ready;
  logic       pc_load, ifid_load, idex_load, exmem_load, memwb_load, ifid_flush, idex_flush;
  logic [15:0] stall_cnt, flush_cnt;
  logic       pc_load4, ifid_load4, idex_load4, exmem_load4, memwb_load4, ifid_flush4, idex_flush4;
  logic [3:0] stall_cnt4, flush_cnt4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_br_taken(ex_br_taken), .mem_req(mem_req),
    .mem_ready(mem_ready), .pc_load(pc_load), .ifid_load(ifid_load),
    .idex_load(idex_load), .exmem_load(exmem_load), .memwb_load(memwb_load),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  hazard_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_br_taken(ex_br_taken), .mem_req(mem_req),
    .mem_ready(mem_ready), .pc_load(pc_load4), .ifid_load(ifid_load4),
    .idex_load(idex_load4), .exmem_load(exmem_load4), .memwb_load(memwb_load4),
    .ifid_flush(ifid_flush4), .idex_flush(idex_flush4),
    .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4));

  // {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush}
  typedef struct {
    logic [4:0] rs1, rs2;
    logic       use1, use2;
    logic [4:0] rd;
    logic       mr, br, mreq, mrdy;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [6:0] ctl();
    return {pc_load, ifid_load, idex_load, exmem_load, memwb_load, ifid_flush, idex_flush};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0; ex_rd = 0;
    ex_mem_read = 0; ex_br_taken = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic set_lu();
    idle();
    ex_mem_read = 1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  initial begin
    logic [15:0] es, ef;
    reset = 1; idle();
    cyc(); cyc();
    chk("reset_stall", stall_cnt, 0);
    chk("reset_flush", flush_cnt, 0);
    chk("reset_state", dut.state_q, RUN);
    chk("reset_outs", ctl(), 7'b1111100);
    reset = 0;

    vecs[0] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b1111100};
    vecs[1] = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0011101};
    vecs[2] = '{5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 7'b1111100};
    vecs[3] = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 7'b1111111};
    vecs[4] = '{5'd0, 5'd7, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0011101};
    vecs[5] = '{5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 7'b1111100};
    vecs[6] = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 7'b1111100};
    vecs[7] = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 7'b0011101};
    vecs[8] = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 7'b0000000};
    vecs[9] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 7'b1111100};

    es = 0; ef = 0;
    for (int i = 0; i < 10; i++) begin
      id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2;
      id_use_rs1 = vecs[i].use1; id_use_rs2 = vecs[i].use2;
      ex_rd = vecs[i].rd; ex_mem_read = vecs[i].mr; ex_br_taken = vecs[i].br;
      mem_req = vecs[i].mreq; mem_ready = vecs[i].mrdy;
      #2;
      chk($sformatf("vec%0d_ctl", i), ctl(), vecs[i].exp);
      if (!vecs[i].exp[6]) es++;
      if (vecs[i].exp[1]) ef++;
      cyc();
      chk($sformatf("vec%0d_stall", i), stall_cnt, es);
      chk($sformatf("vec%0d_flush", i), flush_cnt, ef);
      chk($sformatf("vec%0d_state", i), dut.state_q, (i == 8) ? MEM_WAIT : RUN);
    end

    // Memory wait: three frozen cycles then release.
    idle(); reset = 1; cyc(); reset = 0;
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk($sformatf("mw%0d_ctl", i), ctl(), 7'b0000000);
      cyc();
      chk($sformatf("mw%0d_state", i), dut.state_q, MEM_WAIT);
    end
    mem_ready = 1; #2;
    chk("mw_release_ctl", ctl(), 7'b1111100);
    cyc();
    chk("mw_release_state", dut.state_q, RUN);
    chk("mw_stall_cnt", stall_cnt, 3);
    chk("mw_flush_cnt", flush_cnt, 0);

    // Reset while waiting on memory.
    mem_req = 1; mem_ready = 0; ex_br_taken = 1;
    cyc();
    chk("rmw_state_pre", dut.state_q, MEM_WAIT);
    reset = 1; #2;
    chk("rmw_outs_in_reset", ctl(), 7'b0000000);
    cyc();
    chk("rmw_state", dut.state_q, RUN);
    chk("rmw_stall", stall_cnt, 0);
    chk("rmw_flush", flush_cnt, 0);
    reset = 0; idle();

    // Saturation of the 4-bit counter under a long load-use stall.
    set_lu();
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk($sformatf("sat%0d", i), stall_cnt4, (i + 1 > 15) ? 15 : i + 1);
    end
    chk("sat16_stall", stall_cnt, 20);
    // Branch flushes on the small instance.
    ex_br_taken = 1;
    for (int i = 0; i < 17; i++) cyc();
    chk("sat_flush4", flush_cnt4, 15);
    chk("sat_flush16", flush_cnt, 17);
    chk("sat_stall_hold", stall_cnt4, 15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
